// File: rtl/rtm_sequencer_pkg.sv
// Shared definitions for the register-transfer microprogram sequencer.
//
// Instruction word layout (8 bits):
//   [7:6] op   : OP_LDI / OP_ADD / OP_ADC / OP_HALT
//   [5:4] dst  : destination register
//   [3:2] srcA : A-bus register (LDI: immediate high bits)
//   [1:0] srcB : B-bus register (LDI: immediate low bits)
package rtm_sequencer_pkg;

  localparam int WORD_W = 8;

  localparam logic [1:0] OP_LDI  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ADC  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 6;
  localparam int DST_MSB  = 5;
  localparam int DST_LSB  = 4;
  localparam int SRCA_MSB = 3;
  localparam int SRCA_LSB = 2;
  localparam int SRCB_MSB = 1;
  localparam int SRCB_LSB = 0;
  localparam int IMM_MSB  = 3;
  localparam int IMM_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Control lines presented to the datapath, held for a whole instruction.
  typedef struct packed {
    logic [3:0] indata;
    logic       add;
    logic [1:0] dst;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       cin;
  } ctl_t;

  function automatic logic [1:0] word_op(input logic [WORD_W-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

  // Translate one instruction word into datapath control lines.
  // carry_in follows the carry flag for LDI as well as ADC: the adder result
  // is not selected during LDI, and this keeps the line steady across an
  // LDI that sits between an ADD and the ADC consuming its carry.
  function automatic ctl_t decode_word(input logic [WORD_W-1:0] word,
                                       input logic              cflag);
    ctl_t c;
    c     = '0;
    c.dst = word[DST_MSB:DST_LSB];
    case (word_op(word))
      OP_LDI: begin
        c.indata = word[IMM_MSB:IMM_LSB];
        c.cin    = cflag;
      end
      OP_ADD: begin
        c.add = 1'b1;
        c.sa  = word[SRCA_MSB:SRCA_LSB];
        c.sb  = word[SRCB_MSB:SRCB_LSB];
      end
      OP_ADC: begin
        c.add = 1'b1;
        c.sa  = word[SRCA_MSB:SRCA_LSB];
        c.sb  = word[SRCB_MSB:SRCB_LSB];
        c.cin = cflag;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rtm_sequencer_prog_mem.sv
// rtm_prog_mem: DEPTH x 8 program store, one write port, one synchronous
// read port, no reset.
//
// Ports:
//   clock  : rising-edge clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address, sampled every cycle
//   rdata  : registered read data (word at raddr, one cycle later)
//
// A write and a read to the same address in the same cycle return the new
// word, so a program word loaded together with start is the one fetched.
module rtm_prog_mem
  import rtm_sequencer_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing it would forbid RAM mapping and
  // the program must survive clear_n anyway.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rtm_sequencer.sv
// rtm_sequencer: microprogram sequencer for the 4-register, 4-bit
// register-transfer datapath. Fetches one word at a time from a small
// program store, holds the select lines for SETTLE cycles, then issues a
// single write strobe. Captures adder carry-out for ADC chains.
//
// Ports:
//   clock, clear_n          : clock, synchronous active-low reset
//   prog_we/addr/data       : program load (accepted in IDLE only)
//   start                   : run from address 0 (accepted in IDLE only)
//   carry_out               : adder carry-out from the datapath
//   indata, ctl_add         : immediate value and D-bus select
//   ctl_d0/d1               : destination select (d0 = msb, d1 = lsb)
//   wr                      : write strobe enable, high only in WRITE
//   ctl_sa0/sa1, ctl_sb0/sb1: A/B bus selects (x0 = msb, x1 = lsb)
//   carry_in                : adder carry-in
//   busy, done, overrun     : run status; overrun is sticky until start
module rtm_sequencer
  import rtm_sequencer_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  input  logic              start,
  input  logic              carry_out,
  output logic [3:0]        indata,
  output logic              ctl_add,
  output logic              ctl_d0,
  output logic              ctl_d1,
  output logic              wr,
  output logic              ctl_sa0,
  output logic              ctl_sa1,
  output logic              ctl_sb0,
  output logic              ctl_sb1,
  output logic              carry_in,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     pc;
  logic [AW-1:0]     rd_addr;
  logic [WORD_W-1:0] rd_word;
  logic [1:0]        rd_op;
  logic [1:0]        cur_op;
  logic [CW-1:0]     settle_cnt;
  logic              cflag;
  logic              last_addr;
  ctl_t              ctl;

  // The store has one cycle of read latency, so the address is issued one
  // state early: address 0 while idle, pc+1 while writing. The word for
  // pc is therefore already on rd_word throughout FETCH.
  always_comb begin
    rd_addr = pc;
    if (state == ST_IDLE) begin
      rd_addr = '0;
    end else if (state == ST_WRITE) begin
      rd_addr = pc + AW'(1);
    end
  end

  rtm_prog_mem #(
    .DEPTH(DEPTH)
  ) u_prog_mem (
    .clock (clock),
    .we    (prog_we && (state == ST_IDLE)),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr),
    .rdata (rd_word)
  );

  assign rd_op     = word_op(rd_word);
  assign last_addr = (pc == LAST_ADDR);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next gets its default before the case, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_next = (rd_op == OP_HALT) ? ST_DONE : ST_EXEC;
      end
      ST_EXEC: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_next = last_addr ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Program counter, carry flag, settle timer and the control-output
  // register. Controls load only on FETCH->EXEC and clear on entry to DONE.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      pc         <= '0;
      cflag      <= 1'b0;
      overrun    <= 1'b0;
      cur_op     <= OP_LDI;
      settle_cnt <= '0;
      ctl        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc      <= '0;
            cflag   <= 1'b0;
            overrun <= 1'b0;
          end
        end
        ST_FETCH: begin
          settle_cnt <= '0;
          if (rd_op == OP_HALT) begin
            ctl <= '0;
          end else begin
            ctl    <= decode_word(rd_word, cflag);
            cur_op <= rd_op;
          end
        end
        ST_EXEC: begin
          settle_cnt <= settle_cnt + CW'(1);
        end
        ST_WRITE: begin
          if ((cur_op == OP_ADD) || (cur_op == OP_ADC)) begin
            cflag <= carry_out;
          end
          if (last_addr) begin
            overrun <= 1'b1;
            ctl     <= '0;
          end else begin
            pc <= pc + AW'(1);
          end
        end
        default: begin
          ctl <= '0;
        end
      endcase
    end
  end

  assign indata   = ctl.indata;
  assign ctl_add  = ctl.add;
  assign ctl_d0   = ctl.dst[1];
  assign ctl_d1   = ctl.dst[0];
  assign ctl_sa0  = ctl.sa[1];
  assign ctl_sa1  = ctl.sa[0];
  assign ctl_sb0  = ctl.sb[1];
  assign ctl_sb1  = ctl.sb[0];
  assign carry_in = ctl.cin;

  // Strobe and status decode straight from the state register, so wr falls
  // on the same edge that a clear_n or a state change takes effect.
  assign wr   = (state == ST_WRITE);
  assign done = (state == ST_DONE);
  assign busy = (state == ST_FETCH) || (state == ST_EXEC) || (state == ST_WRITE);

endmodule

// File: tb/tb_rtm_sequencer.sv
// Self-checking bench for rtm_sequencer. Three instances (SETTLE = 2, 1, 4)
// share all inputs. Expected write-strobe control sets are pushed per
// instance when a run is started and popped when that instance raises wr.
module tb_rtm_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int NI    = 3;

  logic       clock;
  logic       clear_n;
  logic       prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       carry_out;

  // {indata[3:0], add, d0, d1, sa0, sa1, sb0, sb1, cin, wr, busy, done, overrun}
  logic [15:0] out_vec [NI];

  logic [10:0] exp_q [NI][$];
  logic [7:0]  mem_model [DEPTH];
  bit          done_seen [NI];
  int          exp_n;
  bit          exp_halt;
  bit          exp_ovr;

  int n_vec;
  int n_err;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected control set for one non-HALT word, straight from the opcode
  // table: LDI drives the immediate with zero bus selects, ADD/ADC drive
  // the bus selects with indata 0, ADD forces carry-in 0.
  function automatic logic [10:0] exp_ctl(input logic [7:0] w, input bit cf);
    logic [1:0] op;
    logic [1:0] dst;
    logic [1:0] a;
    logic [1:0] b;
    op  = w[7:6];
    dst = w[5:4];
    a   = w[3:2];
    b   = w[1:0];
    if (op == 2'b00) begin
      return {w[3:0], 1'b0, dst[1], dst[0], 4'b0000, cf};
    end
    return {4'h0, 1'b1, dst[1], dst[0], a[1], a[0], b[1], b[0],
            (op == 2'b10) ? cf : 1'b0};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    logic [3:0] indata;
    logic ctl_add, ctl_d0, ctl_d1, wr, ctl_sa0, ctl_sa1, ctl_sb0, ctl_sb1;
    logic carry_in, busy, done, overrun;
    logic [10:0] ctl_now;

    rtm_sequencer #(
      .DEPTH  (DEPTH),
      .SETTLE (S)
    ) u_dut (
      .clock     (clock),
      .clear_n   (clear_n),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data),
      .start     (start),
      .carry_out (carry_out),
      .indata    (indata),
      .ctl_add   (ctl_add),
      .ctl_d0    (ctl_d0),
      .ctl_d1    (ctl_d1),
      .wr        (wr),
      .ctl_sa0   (ctl_sa0),
      .ctl_sa1   (ctl_sa1),
      .ctl_sb0   (ctl_sb0),
      .ctl_sb1   (ctl_sb1),
      .carry_in  (carry_in),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
    );

    assign ctl_now = {indata, ctl_add, ctl_d0, ctl_d1, ctl_sa0, ctl_sa1,
                      ctl_sb0, ctl_sb1, carry_in};
    assign out_vec[g] = {ctl_now, wr, busy, done, overrun};

    int          cyc;
    int          wr_idx;
    logic        busy_q;
    logic        done_q;
    logic [10:0] ctl_q;
    logic [10:0] e;

    initial begin
      cyc    = 0;
      wr_idx = 0;
      busy_q = 1'b0;
      done_q = 1'b0;
      ctl_q  = '0;
    end

    // cyc counts cycles from the FETCH of the first instruction.
    always @(negedge clock) begin
      if (busy && !busy_q) begin
        cyc    = 0;
        wr_idx = 0;
      end else begin
        cyc++;
      end
      if (wr) begin
        if (exp_q[g].size() == 0) begin
          check($sformatf("s%0d_wr_unexpected", S), {31'b0, wr}, 0);
        end else begin
          e = exp_q[g].pop_front();
          check($sformatf("s%0d_ctl_at_wr%0d", S, wr_idx), ctl_now, e);
          check($sformatf("s%0d_wr_pos%0d", S, wr_idx), cyc,
                wr_idx * (S + 2) + S + 1);
          wr_idx++;
        end
      end
      if (busy && busy_q && (ctl_now != ctl_q)) begin
        check($sformatf("s%0d_ctl_change_pos", S), cyc % (S + 2), 1);
      end
      if (done_q) begin
        check($sformatf("s%0d_done_width", S), {31'b0, done}, 0);
      end
      if (done) begin
        check($sformatf("s%0d_done_pos", S), cyc,
              exp_n * (S + 2) + (exp_halt ? 1 : 0));
        check($sformatf("s%0d_done_left", S), exp_q[g].size(), 0);
        check($sformatf("s%0d_done_busy", S), {31'b0, busy}, 0);
        check($sformatf("s%0d_done_ctl", S), ctl_now, 0);
        check($sformatf("s%0d_done_ovr", S), {31'b0, overrun}, {31'b0, exp_ovr});
        done_seen[g] = 1'b1;
      end
      busy_q = busy;
      done_q = done;
      ctl_q  = ctl_now;
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int a, input logic [7:0] w);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = w;
    tick();
    prog_we = 1'b0;
    mem_model[a] = w;
  endtask

  task automatic check_all_zero(input string tag);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("%s_out%0d", tag, g), out_vec[g], 0);
    end
  endtask

  // Walk the model program from address 0 and queue the expected strobes.
  task automatic prime;
    int   n;
    bit   h;
    bit   ov;
    bit   cf;
    logic [7:0] w;
    logic [10:0] e;
    n  = 0;
    h  = 1'b0;
    ov = 1'b0;
    cf = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      if (!h && !ov) begin
        w = mem_model[a];
        if (w[7:6] == 2'b11) begin
          h = 1'b1;
        end else begin
          e = exp_ctl(w, cf);
          for (int g = 0; g < NI; g++) exp_q[g].push_back(e);
          n++;
          if (w[7:6] != 2'b00) cf = carry_out;
          if (a == DEPTH - 1) ov = 1'b1;
        end
      end
    end
    exp_n    = n;
    exp_halt = h;
    exp_ovr  = ov;
    for (int g = 0; g < NI; g++) done_seen[g] = 1'b0;
  endtask

  task automatic run(input string tag, input bit disturb, input bit wr0,
                     input logic [7:0] w0);
    bit all_done;
    if (wr0) mem_model[0] = w0;
    prime();
    start = 1'b1;
    if (wr0) begin
      prog_we   = 1'b1;
      prog_addr = '0;
      prog_data = w0;
    end
    tick();
    start   = 1'b0;
    prog_we = 1'b0;
    if (disturb) begin
      tick();
      tick();
      start     = 1'b1;
      prog_we   = 1'b1;
      prog_addr = AW'(1);
      prog_data = 8'hC0;
      tick();
      start   = 1'b0;
      prog_we = 1'b0;
    end
    all_done = 1'b0;
    for (int c = 0; c < 600 && !all_done; c++) begin
      tick();
      all_done = done_seen[0] && done_seen[1] && done_seen[2];
    end
    check({tag, "_finished"}, {31'b0, all_done}, 1);
    tick();
    tick();
  endtask

  task automatic abort_at(input string tag, input int at);
    prime();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (at) tick();
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    check_all_zero(tag);
    for (int g = 0; g < NI; g++) exp_q[g].delete();
    repeat (12) tick();
    check_all_zero({tag, "_quiet"});
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    clear_n   = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;
    carry_out = 1'b0;
    exp_n     = 0;
    exp_halt  = 1'b0;
    exp_ovr   = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem_model[a] = 8'hC0;
    for (int g = 0; g < NI; g++) done_seen[g] = 1'b0;

    repeat (3) tick();
    check_all_zero("reset");
    clear_n = 1'b1;
    tick();
    check_all_zero("idle");

    // LDI r1,5 ; LDI r2,3 ; ADD r3<-r1+r2 ; HALT
    load(0, 8'h15);
    load(1, 8'h23);
    load(2, 8'h76);
    load(3, 8'hC0);
    run("basic", 1'b0, 1'b0, 8'h00);

    // Carry chain with carry_out held high: ADD, LDI, ADC sees carry_in=1.
    carry_out = 1'b1;
    load(0, 8'h0F);
    load(1, 8'h50);
    load(2, 8'h21);
    load(3, 8'hB2);
    load(4, 8'hC0);
    run("carry1", 1'b0, 1'b0, 8'h00);

    // Start clears the flag left at 1: leading ADC has carry_in=0.
    carry_out = 1'b0;
    load(0, 8'h9B);
    load(1, 8'h65);
    load(2, 8'hB6);
    load(3, 8'hC0);
    run("carry0", 1'b0, 1'b0, 8'h00);

    // Every word an LDI: runs off the end and sets overrun.
    for (int i = 0; i < DEPTH; i++) begin
      load(i, {2'b00, i[1:0], i[3:0]});
    end
    run("overrun", 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    for (int g = 0; g < NI; g++) begin
      check($sformatf("ovr_sticky%0d", g), {31'b0, out_vec[g][0]}, 1);
    end

    // HALT written at address 0 together with start: fetched immediately,
    // and the new start clears overrun.
    run("halt_wr_start", 1'b0, 1'b1, 8'hC0);

    // start/prog_we while busy are ignored; a rerun proves memory intact.
    load(0, 8'h15);
    load(1, 8'h23);
    load(2, 8'h76);
    load(3, 8'hC0);
    run("disturb", 1'b1, 1'b0, 8'h00);
    run("after_disturb", 1'b0, 1'b0, 8'h00);

    // Clear during EXEC, then during WRITE (cycle 3 for SETTLE=2).
    abort_at("clr_exec", 1);
    abort_at("clr_write", 3);
    run("restart", 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtm_sequencer.md
# rtm_sequencer

Microprogram sequencer that drives the control inputs of the 4-register, 4-bit register-transfer datapath (register file r0..r3, A/B bus muxes, 4-bit adder, D-bus input mux). It stores a short program, fetches one instruction at a time, and replaces the manual switches. It holds the register-select, bus-select, add-select and carry-in lines stable and issues one write strobe per instruction. It also captures the adder carry-out so that add-with-carry chains work.

## Interface
- DEPTH, 16: program words; address width is log2(DEPTH).
- SETTLE, 2: cycles the selects are held before the write strobe, covering the mux and adder path (≥1).
- clock  in  1  single clock; all state updates on its rising edge.
- clear_n  in  1  reset, synchronous, active-low.
- prog_we  in  1  program-memory write; accepted only in IDLE.
- prog_addr  in  log2(DEPTH)  program write address.
- prog_data  in  8  instruction word [7:6]=op, [5:4]=dst, [3:2]=srcA, [1:0]=srcB or immediate low bits.
- start  in  1  begin execution at address 0; accepted only in IDLE.
- carry_out  in  1  adder carry-out from the datapath.
- indata  out  4  immediate value to the D-bus input mux.
- ctl_add  out  1  D-bus select: 0 = indata, 1 = adder sum.
- ctl_d0, ctl_d1  out  1 each  destination register n, with ctl_d0=n[1] and ctl_d1=n[0].
- wr  out  1  write-strobe enable to the destination decoder.
- ctl_sa0, ctl_sa1  out  1 each  A-bus register n, with ctl_sa0=n[1] and ctl_sa1=n[0].
- ctl_sb0, ctl_sb1  out  1 each  B-bus register n, with ctl_sb0=n[1] and ctl_sb1=n[0].
- carry_in  out  1  adder carry-in.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at program end.
- overrun  out  1  sticky flag: the program ran off the last address. Cleared by start or reset.

## Operation
- Opcodes:
  - 00 LDI: dst ← {srcA,srcB}. indata = prog[3:0], ctl_add = 0.
  - 01 ADD: dst ← r[srcA] + r[srcB], carry_in = 0.
  - 10 ADC: dst ← r[srcA] + r[srcB] + cflag.
  - 11 HALT: stop execution; fields are ignored.
- cflag is internal. It is loaded from carry_out in the WRITE state of ADD and ADC only. LDI leaves it unchanged. Start and reset clear it.
- For ADD and ADC, indata is 0. For LDI, the A/B selects are 0.
- Sum width is 4 bits; overflow is visible only through cflag.
- FSM states are IDLE, FETCH, EXEC, WRITE and DONE:
  - IDLE: on start, set pc=0, clear cflag and overrun, raise busy, go to FETCH.
  - FETCH: perform the registered memory read. Load the control outputs from the word, then go to EXEC. If op is HALT, go to DONE instead.
  - EXEC: hold the controls for SETTLE cycles, then go to WRITE.
  - WRITE: wr=1 for exactly one cycle and cflag is updated. If pc=DEPTH-1, set overrun and go to DONE. Otherwise pc++ and go to FETCH.
  - DONE: done=1 and busy drops on the same cycle. Controls go to 0. Next state is IDLE.
- Controls change only on the FETCH→EXEC edge and are constant through EXEC and WRITE.
- wr is never high outside WRITE.
- prog_we or start outside IDLE is ignored. A simultaneous prog_we and start in IDLE performs both: the write lands first, and fetch at address 0 sees the new word.
- clear_n low at any point returns the block to IDLE on the next edge and drops wr immediately on that edge. Program memory is not cleared.

## Timing
- Reset values: every output is 0, pc=0, cflag=0.
- A non-HALT instruction takes 1 + SETTLE + 1 cycles. HALT takes FETCH + DONE.
- wr rises SETTLE+1 cycles after the FETCH edge. The datapath writes on the wr-gated strobe.
- The carry_out sample lands in cflag at the end of the WRITE cycle and is used by the next ADC.
- done asserts the cycle after the HALT fetch, or the cycle after the last WRITE on overrun.

## Structure
- A shared package holds:
  - opcode constants OP_LDI, OP_ADD, OP_ADC, OP_HALT;
  - the state enum;
  - field-slice constants for the 8-bit word.
- One sub-module, rtm_prog_mem: DEPTH×8 synchronous-read RAM with a single write port and no reset.
- The sequencer FSM and the control-output register stay in rtm_sequencer.

## Test plan
- Load LDI r1,5; LDI r2,3; ADD r3←r1+r2; HALT, then start. Expect 3 wr pulses with ctl_d1/ctl_d0 = 1/0, 0/1, 1/1. Expect indata 5 then 3. During ADD, ctl_sa0/sa1 = 0/1, ctl_sb0/sb1 = 1/0, ctl_add = 1. done appears 1 cycle after the HALT fetch.
- ADD with carry_out=1 forced, then ADC: the ADC has carry_in=1. An intervening LDI keeps carry_in=1.
- Fill all DEPTH words with LDI: expect DEPTH wr pulses, overrun=1, done, return to IDLE. A new start clears overrun.
- Assert start and prog_we while busy: no effect on pc, memory or outputs.
- Pull clear_n low during EXEC and WRITE: outputs are 0 the next cycle and no further wr. A restart executes from address 0 with memory intact.
- SETTLE=1 and SETTLE=4: check that the wr position matches 1+SETTLE cycles after FETCH and that selects are stable throughout.
